// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one wide memory request port between several
// requesters. One transaction is in flight at a time: grant, issue, then wait
// for the matching response (or a timeout), routing the response to its owner.
module mem_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 512,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_buffer_addr_valid,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic [ADDR_W-1:0]         o_address,
  output logic [DATA_W-1:0]         o_write_data,
  output logic                      o_read_request_valid,
  output logic                      o_write_request_valid,
  input  logic                      i_data_valid,
  input  logic                      i_write_done,
  input  logic [DATA_W-1:0]         i_read_data,
  output logic                      o_busy,
  output logic                      o_timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SCN_W = PTR_W + 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_seen;
  logic [PTR_W-1:0]   r_rr;
  logic [PTR_W-1:0]   r_owner;
  logic               r_is_write;
  logic [TMR_W-1:0]   r_timer;
  logic               r_rd_strobe;
  logic               r_wr_strobe;
  logic [ADDR_W-1:0]  r_addr_out;
  logic [DATA_W-1:0]  r_wdata_out;
  logic               r_timeout_err;

  logic               w_gnt_found;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [SCN_W-1:0]   w_scan;
  logic [PTR_W-1:0]   w_rr_next;
  logic               w_grant;
  logic               w_resp_ok;
  logic               w_timeout;

  logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

  // Unpack the flattened per-requester address and payload buses
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = i_req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = i_req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin scan: the first valid requester at or above the pointer wins.
  // Scanning from the far end downward lets the nearest match overwrite others.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr} + SCN_W'(k);
      if (w_scan >= SCN_W'(NUM_REQ)) begin
        w_scan = w_scan - SCN_W'(NUM_REQ);
      end
      if (i_req_valid[w_scan[PTR_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan[PTR_W-1:0];
      end
    end
  end

  assign w_rr_next = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Grant, accepted-response and timeout qualifiers derived from the current state
  always_comb begin
    w_grant   = (r_state == ST_IDLE) && (r_seen || i_buffer_addr_valid) && w_gnt_found;
    w_resp_ok = (r_state == ST_WAIT) && (r_is_write ? i_write_done : i_data_valid);
    w_timeout = (r_state == ST_WAIT) && !w_resp_ok && (r_timer == TMR_W'(TIMEOUT_CYC - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a response in the same cycle as the timeout still completes normally
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT:  if (w_resp_ok || w_timeout) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Combinational outputs: accept pulse to the winner, response routed to the owner
  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_busy      = (r_state != ST_IDLE);
    if (w_grant) begin
      o_req_ready[w_gnt_idx] = 1'b1;
    end
    if (w_resp_ok) begin
      o_rsp_valid[r_owner] = 1'b1;
    end
  end

  // Latch the granted transaction, drive one-cycle strobes, run the response timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen        <= 1'b0;
      r_rr          <= '0;
      r_owner       <= '0;
      r_is_write    <= 1'b0;
      r_timer       <= '0;
      r_rd_strobe   <= 1'b0;
      r_wr_strobe   <= 1'b0;
      r_addr_out    <= '0;
      r_wdata_out   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rd_strobe <= 1'b0;
      r_wr_strobe <= 1'b0;
      if (i_buffer_addr_valid) begin
        r_seen <= 1'b1;
      end
      if (w_grant) begin
        r_owner     <= w_gnt_idx;
        r_is_write  <= i_req_write[w_gnt_idx];
        r_addr_out  <= w_addr_arr[w_gnt_idx];
        r_wdata_out <= w_wdata_arr[w_gnt_idx];
        r_rr        <= w_rr_next;
        r_rd_strobe <= ~i_req_write[w_gnt_idx];
        r_wr_strobe <= i_req_write[w_gnt_idx];
      end
      if (r_state == ST_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == ST_WAIT) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_rsp_rdata           = i_read_data;
  assign o_address             = r_addr_out;
  assign o_write_data          = r_wdata_out;
  assign o_read_request_valid  = r_rd_strobe;
  assign o_write_request_valid = r_wr_strobe;
  assign o_timeout_err         = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset state, buffer gating, single read,
// round-robin ordering, write with stray response, timeout, and mid-flight reset.
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 512;

  logic                      clk;
  logic                      rst_n;
  logic                      buffer_addr_valid;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [ADDR_W-1:0]         address;
  logic [DATA_W-1:0]         write_data;
  logic                      read_request_valid;
  logic                      write_request_valid;
  logic                      data_valid;
  logic                      write_done;
  logic [DATA_W-1:0]         read_data;
  logic                      busy;
  logic                      timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_buffer_addr_valid(buffer_addr_valid),
    .i_req_valid(req_valid),
    .i_req_write(req_write),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata),
    .o_address(address),
    .o_write_data(write_data),
    .o_read_request_valid(read_request_valid),
    .o_write_request_valid(write_request_valid),
    .i_data_valid(data_valid),
    .i_write_done(write_done),
    .i_read_data(read_data),
    .o_busy(busy),
    .o_timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 512'(req_ready), 512'(0));
    chk({tag, "_rsp"},   512'(rsp_valid), 512'(0));
    chk({tag, "_addr"},  512'(address), 512'(0));
    chk({tag, "_wdata"}, write_data, 512'(0));
    chk({tag, "_rd"},    512'(read_request_valid), 512'(0));
    chk({tag, "_wr"},    512'(write_request_valid), 512'(0));
    chk({tag, "_busy"},  512'(busy), 512'(0));
    chk({tag, "_tmo"},   512'(timeout_err), 512'(0));
  endtask

  logic [DATA_W-1:0] d1, d2, d3, d4, a5;
  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    d1 = {16{32'h1111_2222}};
    d2 = {16{32'hDEAD_BEEF}};
    d3 = {16{32'h0BAD_F00D}};
    d4 = {16{32'h7777_0000}};
    a5 = {64{8'hA5}};
    rst_n = 1'b0;
    buffer_addr_valid = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    data_valid = 1'b0;
    write_done = 1'b0;
    read_data  = '0;

    // Reset state
    cyc();
    cyc();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Test 4: no grant before buffer_addr_valid has ever been seen
    for (int i = 0; i < 10; i++) begin
      cyc();
      req_valid = 4'b0010;
      req_addr[1*ADDR_W +: ADDR_W] = 32'h200;
      #1;
      chk("t4_gated_ready", 512'(req_ready), 512'(0));
      chk("t4_gated_rd", 512'(read_request_valid), 512'(0));
    end
    cyc();
    buffer_addr_valid = 1'b1;
    #1;
    chk("t4_ready", 512'(req_ready), 512'(4'b0010));
    cyc();
    req_valid = '0;
    #1;
    chk("t4_rd", 512'(read_request_valid), 512'(1));
    chk("t4_addr", 512'(address), 512'(32'h200));
    chk("t4_busy", 512'(busy), 512'(1));
    cyc();
    data_valid = 1'b1;
    read_data = d1;
    #1;
    chk("t4_rsp", 512'(rsp_valid), 512'(4'b0010));
    chk("t4_rdata", rsp_rdata, d1);
    cyc();
    data_valid = 1'b0;
    #1;
    chk("t4_rsp_off", 512'(rsp_valid), 512'(0));
    chk("t4_idle", 512'(busy), 512'(0));

    // Test 1: single read from requester 0, response three cycles after the strobe
    cyc();
    req_valid = 4'b0001;
    req_addr[0 +: ADDR_W] = 32'h100;
    #1;
    chk("t1_ready", 512'(req_ready), 512'(4'b0001));
    cyc();
    req_valid = '0;
    #1;
    chk("t1_rd", 512'(read_request_valid), 512'(1));
    chk("t1_wr", 512'(write_request_valid), 512'(0));
    chk("t1_addr", 512'(address), 512'(32'h100));
    cyc();
    #1;
    chk("t1_rd_once", 512'(read_request_valid), 512'(0));
    chk("t1_rsp_w1", 512'(rsp_valid), 512'(0));
    cyc();
    #1;
    chk("t1_rsp_w2", 512'(rsp_valid), 512'(0));
    cyc();
    data_valid = 1'b1;
    read_data = d2;
    #1;
    chk("t1_rsp", 512'(rsp_valid), 512'(4'b0001));
    chk("t1_rdata", rsp_rdata, d2);
    cyc();
    data_valid = 1'b0;
    #1;
    chk("t1_idle", 512'(busy), 512'(0));

    // Test 2: all four requesting, one-cycle memory, pointer restarted by reset
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = 32'h1000 + 32'(i * 16);
    end
    data_valid = 1'b1;
    read_data = d3;
    for (int t = 0; t < 6; t++) begin
      cyc();
      req_valid = 4'b1111;
      #1;
      chk($sformatf("t2_ready_%0d", t), 512'(req_ready), 512'(4'b0001 << order[t]));
      cyc();
      #1;
      chk($sformatf("t2_rd_%0d", t), 512'(read_request_valid), 512'(1));
      chk($sformatf("t2_addr_%0d", t), 512'(address), 512'(32'h1000 + 32'(order[t] * 16)));
      chk($sformatf("t2_noready_%0d", t), 512'(req_ready), 512'(0));
      cyc();
      #1;
      chk($sformatf("t2_rsp_%0d", t), 512'(rsp_valid), 512'(4'b0001 << order[t]));
    end
    cyc();
    req_valid = '0;
    data_valid = 1'b0;
    #1;
    chk("t2_idle", 512'(busy), 512'(0));

    // Test 3: write from requester 2 with a stray data_valid while waiting
    cyc();
    req_valid = 4'b0100;
    req_write = 4'b0100;
    req_addr[2*ADDR_W +: ADDR_W] = 32'h40;
    req_wdata[2*DATA_W +: DATA_W] = a5;
    #1;
    chk("t3_ready", 512'(req_ready), 512'(4'b0100));
    cyc();
    req_valid = '0;
    #1;
    chk("t3_wr", 512'(write_request_valid), 512'(1));
    chk("t3_rd", 512'(read_request_valid), 512'(0));
    chk("t3_wdata", write_data, a5);
    chk("t3_addr", 512'(address), 512'(32'h40));
    cyc();
    #1;
    chk("t3_wr_once", 512'(write_request_valid), 512'(0));
    chk("t3_rsp_w1", 512'(rsp_valid), 512'(0));
    cyc();
    data_valid = 1'b1;
    #1;
    chk("t3_stray", 512'(rsp_valid), 512'(0));
    cyc();
    data_valid = 1'b0;
    #1;
    chk("t3_busy", 512'(busy), 512'(1));
    cyc();
    #1;
    cyc();
    write_done = 1'b1;
    #1;
    chk("t3_rsp", 512'(rsp_valid), 512'(4'b0100));
    cyc();
    write_done = 1'b0;
    req_write = '0;
    #1;
    chk("t3_idle", 512'(busy), 512'(0));

    // Test 5: read from requester 3 never answered; requester 0 waits behind it
    cyc();
    req_valid = 4'b1000;
    req_addr[3*ADDR_W +: ADDR_W] = 32'h300;
    #1;
    chk("t5_ready", 512'(req_ready), 512'(4'b1000));
    cyc();
    req_valid = '0;
    #1;
    chk("t5_rd", 512'(read_request_valid), 512'(1));
    for (int w = 1; w <= 15; w++) begin
      cyc();
      req_valid = 4'b0001;
      #1;
      chk($sformatf("t5_noready_%0d", w), 512'(req_ready), 512'(0));
      chk($sformatf("t5_tmo_early_%0d", w), 512'(timeout_err), 512'(0));
    end
    cyc();
    #1;
    chk("t5_last_rsp", 512'(rsp_valid), 512'(0));
    chk("t5_last_busy", 512'(busy), 512'(1));
    cyc();
    #1;
    chk("t5_tmo", 512'(timeout_err), 512'(1));
    chk("t5_busy", 512'(busy), 512'(0));
    chk("t5_next_ready", 512'(req_ready), 512'(4'b0001));
    cyc();
    req_valid = '0;
    #1;
    chk("t5_next_rd", 512'(read_request_valid), 512'(1));
    chk("t5_next_addr", 512'(address), 512'(32'h1000));
    chk("t5_tmo_sticky", 512'(timeout_err), 512'(1));

    // Test 6: reset while waiting, then a late response after release
    cyc();
    #1;
    chk("t6_busy", 512'(busy), 512'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    cyc();
    cyc();
    rst_n = 1'b1;
    data_valid = 1'b1;
    read_data = d4;
    #1;
    chk("t6_late_rsp", 512'(rsp_valid), 512'(0));
    chk("t6_late_busy", 512'(busy), 512'(0));
    cyc();
    #1;
    chk("t6_late_rsp2", 512'(rsp_valid), 512'(0));
    chk("t6_late_rd", 512'(read_request_valid), 512'(0));
    data_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
